// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the multiplier sequencer/arbiter.
// Operation encodings, FSM states, requester IDs and the operand
// signedness rules used when extending operands for the Booth encoder.
package mult_sched_pkg;

    localparam int DEFAULT_LENGTH = 32;
    localparam int DEFAULT_LAT    = 2;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mult_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } sched_state_e;

    typedef enum logic {
        CORE = 1'b0,
        ACC  = 1'b1
    } req_id_e;

    // Operand a is signed for every op except MULHU.
    function automatic logic op_a_signed(input mult_op_e op);
        return (op != MULHU);
    endfunction

    // Operand b is signed only for MUL and MULH.
    function automatic logic op_b_signed(input mult_op_e op);
        return ((op == MUL) || (op == MULH));
    endfunction

endpackage

// File: rtl/mult_sched_arb.sv
// Two-request arbiter for the shared multiplier.
// Build option MULT_SCHED_RR_EN: two-way round-robin with a pointer that
// moves to the loser on every grant; otherwise core has fixed priority.
// Grants are combinational and qualified by 'en' (scheduler idle).
module mult_sched_arb
    import mult_sched_pkg::*;
(
`ifdef MULT_SCHED_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en,
    input  logic core_req,
    input  logic acc_req,
    output logic core_gnt,
    output logic acc_gnt
);

`ifdef MULT_SCHED_RR_EN
    req_id_e ptr_r;
    logic    pick_acc_s;

    // Acc wins when it is alone or when the pointer favours it.
    always_comb begin
        pick_acc_s = acc_req & (~core_req | (ptr_r == ACC));
    end

    assign core_gnt = en & core_req & ~pick_acc_s;
    assign acc_gnt  = en & pick_acc_s;

    // Pointer moves to the non-winner whenever a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= CORE;
        end else if (core_gnt) begin
            ptr_r <= ACC;
        end else if (acc_gnt) begin
            ptr_r <= CORE;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    assign core_gnt = en & core_req;
    assign acc_gnt  = en & acc_req & ~core_req;
`endif

endmodule

// File: rtl/mult_sched.sv
// Sequencer for the shared radix-8 Booth multiplier datapath.
// Grants one of two requesters, extends its operands to LENGTH+1 bits,
// holds the datapath enable for LAT cycles, captures the result and
// pulses the winner's valid for one cycle.
// Build option MULT_SCHED_RR_EN selects round-robin arbitration.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int LENGTH = DEFAULT_LENGTH,
    parameter int LAT    = DEFAULT_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req_i,
    input  logic [1:0]        core_op_i,
    input  logic [LENGTH-1:0] core_a_i,
    input  logic [LENGTH-1:0] core_b_i,
    output logic              core_gnt_o,
    output logic              core_valid_o,
    output logic [LENGTH-1:0] core_result_o,
    input  logic              acc_req_i,
    input  logic [1:0]        acc_op_i,
    input  logic [LENGTH-1:0] acc_a_i,
    input  logic [LENGTH-1:0] acc_b_i,
    output logic              acc_gnt_o,
    output logic              acc_valid_o,
    output logic [LENGTH-1:0] acc_result_o,
    output logic              dp_enable_o,
    output logic              dp_operation_o,
    output logic [LENGTH:0]   dp_a_o,
    output logic [LENGTH:0]   dp_b_o,
    input  logic [LENGTH-1:0] dp_result_i,
    output logic              busy_o
);

    localparam int              CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    sched_state_e      state_r;
    logic [CNT_W-1:0]  cnt_r;
    req_id_e           winner_r;
    logic              busy_r;
    logic              core_valid_r;
    logic              acc_valid_r;
    logic [LENGTH-1:0] core_result_r;
    logic [LENGTH-1:0] acc_result_r;
    logic              dp_enable_r;
    logic              dp_operation_r;
    logic [LENGTH:0]   dp_a_r;
    logic [LENGTH:0]   dp_b_r;

    logic              arb_en_s;
    logic              core_gnt_s;
    logic              acc_gnt_s;
    logic              take_s;
    mult_op_e          sel_op_s;
    logic [LENGTH-1:0] sel_a_s;
    logic [LENGTH-1:0] sel_b_s;
    logic [LENGTH:0]   ext_a_s;
    logic [LENGTH:0]   ext_b_s;

    // Grants are only offered in IDLE and are forced low while reset is held.
    assign arb_en_s = (state_r == IDLE) & rst_n;

    mult_sched_arb u_arb (
`ifdef MULT_SCHED_RR_EN
        .clk      (clk),
        .rst_n    (rst_n),
`endif
        .en       (arb_en_s),
        .core_req (core_req_i),
        .acc_req  (acc_req_i),
        .core_gnt (core_gnt_s),
        .acc_gnt  (acc_gnt_s)
    );

    // Select the winner's request fields and extend operands for the encoder.
    always_comb begin
        take_s   = core_gnt_s | acc_gnt_s;
        sel_op_s = acc_gnt_s ? mult_op_e'(acc_op_i) : mult_op_e'(core_op_i);
        sel_a_s  = acc_gnt_s ? acc_a_i : core_a_i;
        sel_b_s  = acc_gnt_s ? acc_b_i : core_b_i;
        ext_a_s  = {op_a_signed(sel_op_s) & sel_a_s[LENGTH-1], sel_a_s};
        ext_b_s  = {op_b_signed(sel_op_s) & sel_b_s[LENGTH-1], sel_b_s};
    end

    // Scheduler FSM: latch on grant, count the settle window, capture, pulse valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            winner_r       <= CORE;
            busy_r         <= 1'b0;
            core_valid_r   <= 1'b0;
            acc_valid_r    <= 1'b0;
            core_result_r  <= '0;
            acc_result_r   <= '0;
            dp_enable_r    <= 1'b0;
            dp_operation_r <= 1'b0;
            dp_a_r         <= '0;
            dp_b_r         <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        state_r        <= BUSY;
                        cnt_r          <= '0;
                        winner_r       <= acc_gnt_s ? ACC : CORE;
                        busy_r         <= 1'b1;
                        dp_enable_r    <= 1'b1;
                        dp_operation_r <= (sel_op_s != MUL);
                        dp_a_r         <= ext_a_s;
                        dp_b_r         <= ext_b_s;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= DONE;
                        cnt_r       <= '0;
                        dp_enable_r <= 1'b0;
                        if (winner_r == ACC) begin
                            acc_result_r <= dp_result_i;
                            acc_valid_r  <= 1'b1;
                        end else begin
                            core_result_r <= dp_result_i;
                            core_valid_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    core_valid_r <= 1'b0;
                    acc_valid_r  <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= '0;
                    busy_r       <= 1'b0;
                    dp_enable_r  <= 1'b0;
                    core_valid_r <= 1'b0;
                    acc_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign core_gnt_o     = core_gnt_s;
    assign acc_gnt_o      = acc_gnt_s;
    assign core_valid_o   = core_valid_r;
    assign acc_valid_o    = acc_valid_r;
    assign core_result_o  = core_result_r;
    assign acc_result_o   = acc_result_r;
    assign dp_enable_o    = dp_enable_r;
    assign dp_operation_o = dp_operation_r;
    assign dp_a_o         = dp_a_r;
    assign dp_b_o         = dp_b_r;
    assign busy_o         = busy_r;

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: transaction-level reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_mult_sched;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        core_req_i, acc_req_i;
    logic [1:0]  core_op_i, acc_op_i;
    logic [31:0] core_a_i, core_b_i, acc_a_i, acc_b_i;
    logic        core_gnt_o, core_valid_o, acc_gnt_o, acc_valid_o;
    logic [31:0] core_result_o, acc_result_o;
    logic        dp_enable_o, dp_operation_o, busy_o;
    logic [32:0] dp_a_o, dp_b_o;
    logic [31:0] dp_result_i;

    int n_pass  = 0;
    int n_total = 0;

    mult_sched #(.LENGTH(32), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_op_i(core_op_i), .core_a_i(core_a_i), .core_b_i(core_b_i),
        .core_gnt_o(core_gnt_o), .core_valid_o(core_valid_o), .core_result_o(core_result_o),
        .acc_req_i(acc_req_i), .acc_op_i(acc_op_i), .acc_a_i(acc_a_i), .acc_b_i(acc_b_i),
        .acc_gnt_o(acc_gnt_o), .acc_valid_o(acc_valid_o), .acc_result_o(acc_result_o),
        .dp_enable_o(dp_enable_o), .dp_operation_o(dp_operation_o),
        .dp_a_o(dp_a_o), .dp_b_o(dp_b_o), .dp_result_i(dp_result_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: full signed product of the extended operands.
    logic signed [65:0] dp_prod;
    always_comb begin
        dp_prod     = $signed(dp_a_o) * $signed(dp_b_o);
        dp_result_i = dp_operation_o ? dp_prod[63:32] : dp_prod[31:0];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference result from 64-bit arithmetic on the architectural operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (op != 2'd3) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op <= 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [32:0] ref_ext(input logic sgn, input logic [31:0] v);
        return sgn ? {v[31], v} : {1'b0, v};
    endfunction

    // Transaction-level model: cycles since grant decide every output.
    int          m_cyc = 0;
    bit          m_win = 1'b0;
`ifdef MULT_SCHED_RR_EN
    bit          m_ptr = 1'b0;
`endif
    logic        m_oph = 1'b0;
    logic [32:0] m_a = '0, m_b = '0;
    logic [31:0] m_pend = '0, m_core_res = '0, m_acc_res = '0;

    // Per-cycle compare of all outputs against the model, then model advance.
    always @(negedge clk) begin
        bit eg_c, eg_a;
        logic [1:0]  op;
        logic [31:0] a, b;
        eg_c = 1'b0; eg_a = 1'b0;
        if (!rst_n) begin
            m_cyc = 0; m_win = 1'b0; m_oph = 1'b0; m_a = '0; m_b = '0;
            m_core_res = '0; m_acc_res = '0;
`ifdef MULT_SCHED_RR_EN
            m_ptr = 1'b0;
`endif
        end else if (m_cyc == 0) begin
            if (core_req_i && acc_req_i) begin
`ifdef MULT_SCHED_RR_EN
                if (m_ptr) eg_a = 1'b1; else eg_c = 1'b1;
`else
                eg_c = 1'b1;
`endif
            end else if (core_req_i) eg_c = 1'b1;
            else if (acc_req_i) eg_a = 1'b1;
        end
        check("core_gnt", 64'(core_gnt_o), 64'(eg_c));
        check("acc_gnt", 64'(acc_gnt_o), 64'(eg_a));
        check("busy", 64'(busy_o), 64'(m_cyc != 0));
        check("dp_enable", 64'(dp_enable_o), 64'(m_cyc >= 1 && m_cyc <= LAT));
        check("core_valid", 64'(core_valid_o), 64'(m_cyc == LAT + 1 && !m_win));
        check("acc_valid", 64'(acc_valid_o), 64'(m_cyc == LAT + 1 && m_win));
        check("core_result", 64'(core_result_o), 64'(m_core_res));
        check("acc_result", 64'(acc_result_o), 64'(m_acc_res));
        check("dp_operation", 64'(dp_operation_o), 64'(m_oph));
        check("dp_a", 64'(dp_a_o), 64'(m_a));
        check("dp_b", 64'(dp_b_o), 64'(m_b));
        if (rst_n) begin
            if (eg_c || eg_a) begin
                op = eg_a ? acc_op_i : core_op_i;
                a  = eg_a ? acc_a_i : core_a_i;
                b  = eg_a ? acc_b_i : core_b_i;
                m_win  = eg_a;
                m_oph  = (op != 2'd0);
                m_a    = ref_ext(op != 2'd3, a);
                m_b    = ref_ext(op <= 2'd1, b);
                m_pend = ref_mul(op, a, b);
`ifdef MULT_SCHED_RR_EN
                m_ptr  = ~eg_a;
`endif
                m_cyc  = 1;
            end else if (m_cyc == LAT + 1) begin
                m_cyc = 0;
            end else if (m_cyc != 0) begin
                m_cyc++;
                if (m_cyc == LAT + 1) begin
                    if (m_win) m_acc_res = m_pend; else m_core_res = m_pend;
                end
            end
        end
    end

    task automatic drive(input bit who_acc, input bit req, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (who_acc) begin acc_req_i = req; acc_op_i = op; acc_a_i = a; acc_b_i = b; end
        else begin core_req_i = req; core_op_i = op; core_a_i = a; core_b_i = b; end
    endtask

    // One request: wait for grant, check latched operands, latency and result.
    task automatic run_txn(input string nm, input bit who_acc, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [32:0] e_a, input logic [32:0] e_b,
                           input logic [31:0] e_res, output int gwait);
        bit got;
        int lat;
        drive(who_acc, 1'b1, op, a, b);
        got = 1'b0; gwait = 0;
        while (!got && gwait < 20) begin
            @(negedge clk); gwait++;
            if (who_acc ? acc_gnt_o : core_gnt_o) got = 1'b1;
        end
        check({nm, "_granted"}, 64'(got), 64'd1);
        @(posedge clk); #2;
        drive(who_acc, 1'b0, op, a, b);
        @(negedge clk);
        check({nm, "_dp_a"}, 64'(dp_a_o), 64'(e_a));
        check({nm, "_dp_b"}, 64'(dp_b_o), 64'(e_b));
        check({nm, "_dp_op"}, 64'(dp_operation_o), 64'(op != 2'd0));
        lat = 1; got = 1'b0;
        while (!got && lat < 20) begin
            if (who_acc ? acc_valid_o : core_valid_o) got = 1'b1;
            else begin @(negedge clk); lat++; end
        end
        check({nm, "_latency"}, 64'(lat), 64'(LAT + 1));
        check({nm, "_result"}, 64'(who_acc ? acc_result_o : core_result_o), 64'(e_res));
        @(posedge clk); #2;
    endtask

    initial begin
        int gw, ng, nacc, nvalid, to;
        int gcyc[3];
        bit gwho[3];
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_core_result", 64'(core_result_o), 64'd0);
        @(posedge clk); #2;

        run_txn("core_mul", 1'b0, 2'd0, 32'd7, 32'hFFFF_FFFD, 33'h0_0000_0007, 33'h1_FFFF_FFFD, 32'hFFFF_FFEB, gw);
        run_txn("core_mulhu", 1'b0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 32'hFFFF_FFFE, gw);
        run_txn("acc_mulh", 1'b1, 2'd1, 32'h8000_0000, 32'h8000_0000, 33'h1_8000_0000, 33'h1_8000_0000, 32'h4000_0000, gw);
        run_txn("acc_mulhsu", 1'b1, 2'd2, 32'hFFFF_FFFF, 32'd2, 33'h1_FFFF_FFFF, 33'h0_0000_0002, 32'hFFFF_FFFF, gw);

        // Core in flight while acc waits: acc side must stay untouched.
        drive(1'b0, 1'b1, 2'd0, 32'd5, 32'd6);
        to = 0;
        do begin @(negedge clk); to++; end while (!core_gnt_o && to < 20);
        check("pend_core_granted", 64'(core_gnt_o), 64'd1);
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 2'd0, 32'd5, 32'd6);
        drive(1'b1, 1'b1, 2'd2, 32'h10, 32'h8000_0000);
        to = 0;
        do begin @(negedge clk); to++; end while (!core_valid_o && to < 20);
        check("pend_core_valid", 64'(core_valid_o), 64'd1);
        check("pend_core_result", 64'(core_result_o), 64'd30);
        check("pend_acc_valid", 64'(acc_valid_o), 64'd0);
        check("pend_acc_result", 64'(acc_result_o), 64'hFFFF_FFFF);
        @(posedge clk); #2;
        run_txn("pend_acc", 1'b1, 2'd2, 32'h10, 32'h8000_0000, 33'h0_0000_0010, 33'h0_8000_0000, 32'd8, gw);
        check("pend_acc_wait", 64'(gw), 64'd1);

        // Both requests held continuously from reset.
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 2'd0, 32'd3, 32'd4);
        drive(1'b1, 1'b1, 2'd0, 32'd5, 32'd7);
        @(negedge clk);
        check("rst_core_gnt", 64'(core_gnt_o), 64'd0);
        check("rst_acc_gnt", 64'(acc_gnt_o), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        ng = 0; nacc = 0; to = 0;
        while (ng < 3 && to < 40) begin
            @(negedge clk);
            if (acc_gnt_o) nacc++;
            if (core_gnt_o || acc_gnt_o) begin
                gcyc[ng] = to; gwho[ng] = acc_gnt_o; ng++;
            end
            to++;
        end
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 2'd0, 32'd3, 32'd4);
        drive(1'b1, 1'b0, 2'd0, 32'd5, 32'd7);
        check("both_grant_count", 64'(ng), 64'd3);
        if (ng == 3) begin
            check("both_first_cycle", 64'(gcyc[0]), 64'd0);
            check("both_space1", 64'(gcyc[1] - gcyc[0]), 64'(LAT + 2));
            check("both_space2", 64'(gcyc[2] - gcyc[1]), 64'(LAT + 2));
`ifdef MULT_SCHED_RR_EN
            check("both_who0", 64'(gwho[0]), 64'd0);
            check("both_who1", 64'(gwho[1]), 64'd1);
            check("both_who2", 64'(gwho[2]), 64'd0);
`else
            check("both_who0", 64'(gwho[0]), 64'd0);
            check("both_who2", 64'(gwho[2]), 64'd0);
            check("both_acc_never", 64'(nacc), 64'd0);
`endif
        end
        repeat (LAT + 3) @(posedge clk);
        #2;

        // Reset pulsed in BUSY cycle 1 drops the in-flight request.
        drive(1'b0, 1'b1, 2'd0, 32'd2, 32'd3);
        to = 0;
        do begin @(negedge clk); to++; end while (!core_gnt_o && to < 20);
        check("rstmid_granted", 64'(core_gnt_o), 64'd1);
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 2'd0, 32'd2, 32'd3);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 64'(busy_o), 64'd0);
        check("rstmid_enable", 64'(dp_enable_o), 64'd0);
        check("rstmid_dp_a", 64'(dp_a_o), 64'd0);
        check("rstmid_core_result", 64'(core_result_o), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        nvalid = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (core_valid_o || acc_valid_o) nvalid++;
        end
        check("rstmid_no_valid", 64'(nvalid), 64'd0);
        @(posedge clk); #2;
        run_txn("after_rst", 1'b0, 2'd0, 32'd9, 32'd9, 33'h0_0000_0009, 33'h0_0000_0009, 32'd81, gw);
        check("after_rst_wait", 64'(gw), 64'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
